// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and elaboration helpers for the VGA timing counters.
// Each axis lists total / active / sync start / sync end, plus the asserted sync level.
package vga_timing_pkg;

    localparam int   DEFAULT_WIDTH  = 10;

    localparam int   H_TOTAL        = 800;
    localparam int   H_ACTIVE       = 640;
    localparam int   H_SYNC_START   = 656;
    localparam int   H_SYNC_END     = 752;
    localparam logic H_SYNC_POL     = 1'b0;

    localparam int   V_TOTAL        = 525;
    localparam int   V_ACTIVE       = 480;
    localparam int   V_SYNC_START   = 490;
    localparam int   V_SYNC_END     = 492;
    localparam logic V_SYNC_POL     = 1'b0;

    // True when every value 0 .. modulus-1 is representable in 'width' bits.
    function automatic bit fits_in_width(input int width, input int modulus);
        return longint'(modulus) <= (longint'(1) << width);
    endfunction

endpackage

// File: rtl/vga_window_cmp.sv
// Half-open window compare: o_in = (LO <= i_x < HI). Bounds may reach 2^WIDTH,
// so the compare is carried out one bit wider than the input.
module vga_window_cmp #(
    parameter int WIDTH = 10,
    parameter int LO    = 0,
    parameter int HI    = 1
) (
    input  logic [WIDTH-1:0] i_x,
    output logic             o_in
);

    localparam logic [WIDTH:0] L_HI = (WIDTH+1)'(HI);

    logic [WIDTH:0] w_x;
    logic           w_below_hi;

    assign w_x        = {1'b0, i_x};
    assign w_below_hi = (w_x < L_HI);

    // A zero lower bound is always met, so it gets no comparator at all.
    generate
        if (LO == 0) begin : g_from_zero
            assign o_in = w_below_hi;
        end else begin : g_window
            localparam logic [WIDTH:0] L_LO = (WIDTH+1)'(LO);
            assign o_in = (w_x >= L_LO) && w_below_hi;
        end
    endgenerate

endmodule

// File: rtl/vga_sync_counter.sv
// Modulo-MODULUS position counter with saturating load, cascade carry (Tc) and
// registered Active/Sync outputs that always describe the current Q.
module vga_sync_counter
    import vga_timing_pkg::*;
#(
    parameter int   WIDTH      = DEFAULT_WIDTH,
    parameter int   MODULUS    = H_TOTAL,
    parameter int   ACTIVE     = H_ACTIVE,
    parameter int   SYNC_START = H_SYNC_START,
    parameter int   SYNC_END   = H_SYNC_END,
    parameter logic SYNC_POL   = H_SYNC_POL
) (
    input  logic             Clock,
    input  logic             Clear,
    input  logic             Count,
    input  logic             Load,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             Tc,
    output logic             Active,
    output logic             Sync
);

    generate
        if (MODULUS < 2) begin : g_err_mod_small
            $error("vga_sync_counter: MODULUS must be at least 2");
        end
        if (!fits_in_width(WIDTH, MODULUS)) begin : g_err_mod_wide
            $error("vga_sync_counter: MODULUS exceeds 2^WIDTH");
        end
        if (ACTIVE < 0 || ACTIVE > MODULUS) begin : g_err_active
            $error("vga_sync_counter: ACTIVE must lie in [0, MODULUS]");
        end
        if (SYNC_START >= SYNC_END || SYNC_END > MODULUS) begin : g_err_sync
            $error("vga_sync_counter: need SYNC_START < SYNC_END <= MODULUS");
        end
    endgenerate

    localparam logic [WIDTH:0]   L_MOD_EXT = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] L_Q_MAX   = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] r_q;
    logic             r_active;
    logic             r_sync;

    logic             w_at_max;
    logic             w_d_in_range;
    logic [WIDTH-1:0] w_d_sat;
    logic [WIDTH-1:0] w_q_next;
    logic             w_in_active;
    logic             w_in_sync;

    assign w_at_max     = (r_q == L_Q_MAX);
    // D is widened so the range test stays correct when MODULUS == 2^WIDTH.
    assign w_d_in_range = ({1'b0, D} < L_MOD_EXT);
    assign w_d_sat      = w_d_in_range ? D : L_Q_MAX;

    always_comb begin
        w_q_next = r_q;
        if (Load) begin
            w_q_next = w_d_sat;
        end else if (Count) begin
            w_q_next = w_at_max ? '0 : r_q + 1'b1;
        end
    end

    // Carry is asserted only in the cycle whose edge wraps this counter to 0.
    assign Tc = Count & ~Load & w_at_max;

    vga_window_cmp #(
        .WIDTH (WIDTH),
        .LO    (0),
        .HI    (ACTIVE)
    ) u_active_win (
        .i_x   (w_q_next),
        .o_in  (w_in_active)
    );

    vga_window_cmp #(
        .WIDTH (WIDTH),
        .LO    (SYNC_START),
        .HI    (SYNC_END)
    ) u_sync_win (
        .i_x   (w_q_next),
        .o_in  (w_in_sync)
    );

    // Windows are evaluated on the next count so the flops line up with Q.
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            r_q      <= '0;
            r_active <= 1'b1;
            r_sync   <= ~SYNC_POL;
        end else begin
            r_q      <= w_q_next;
            r_active <= w_in_active;
            r_sync   <= w_in_sync ? SYNC_POL : ~SYNC_POL;
        end
    end

    assign Q      = r_q;
    assign Active = r_active;
    assign Sync   = r_sync;

endmodule

// File: tb/tb_vga_sync_counter.sv
// Bench for vga_sync_counter: an 800-pixel H counter cascaded into a 525-line V
// counter, plus a small 12-state instance with a positive sync at the top boundary.
module tb_vga_sync_counter;

    localparam int HM = 800, HA = 640, HS0 = 656, HS1 = 752;
    localparam int VM = 525, VA = 480, VS0 = 490, VS1 = 492;
    localparam int SM = 12,  SA = 7,   SS0 = 8,   SS1 = 12;

    logic       clk = 1'b0;
    logic       clear_n;

    logic       h_count, h_load;
    logic [9:0] h_d;
    logic [9:0] h_q;
    logic       h_tc, h_act, h_sync;

    logic       v_load;
    logic [9:0] v_d;
    logic [9:0] v_q;
    logic       v_tc, v_act, v_sync;

    logic       s_count, s_load;
    logic [3:0] s_d;
    logic [3:0] s_q;
    logic       s_tc, s_act, s_sync;

    int checks = 0;
    int errors = 0;
    int mh = 0, mv = 0, ms = 0;

    always #5 clk = ~clk;

    vga_sync_counter u_h (
        .Clock  (clk),
        .Clear  (clear_n),
        .Count  (h_count),
        .Load   (h_load),
        .D      (h_d),
        .Q      (h_q),
        .Tc     (h_tc),
        .Active (h_act),
        .Sync   (h_sync)
    );

    vga_sync_counter #(
        .WIDTH      (10),
        .MODULUS    (vga_timing_pkg::V_TOTAL),
        .ACTIVE     (vga_timing_pkg::V_ACTIVE),
        .SYNC_START (vga_timing_pkg::V_SYNC_START),
        .SYNC_END   (vga_timing_pkg::V_SYNC_END),
        .SYNC_POL   (vga_timing_pkg::V_SYNC_POL)
    ) u_v (
        .Clock  (clk),
        .Clear  (clear_n),
        .Count  (h_tc),
        .Load   (v_load),
        .D      (v_d),
        .Q      (v_q),
        .Tc     (v_tc),
        .Active (v_act),
        .Sync   (v_sync)
    );

    vga_sync_counter #(
        .WIDTH      (4),
        .MODULUS    (SM),
        .ACTIVE     (SA),
        .SYNC_START (SS0),
        .SYNC_END   (SS1),
        .SYNC_POL   (1'b1)
    ) u_s (
        .Clock  (clk),
        .Clear  (clear_n),
        .Count  (s_count),
        .Load   (s_load),
        .D      (s_d),
        .Q      (s_q),
        .Tc     (s_tc),
        .Active (s_act),
        .Sync   (s_sync)
    );

    // Reference rules: saturating load beats counting, counting wraps at the modulus.
    function automatic int m_next(input int q, input bit ld, input bit cn, input int d, input int m);
        if (ld) return (d < m) ? d : m - 1;
        if (cn) return (q == m - 1) ? 0 : q + 1;
        return q;
    endfunction

    function automatic bit m_tc(input int q, input bit ld, input bit cn, input int m);
        return cn && !ld && (q == m - 1);
    endfunction

    function automatic bit m_sync(input int q, input int lo, input int hi, input bit pol);
        return (q >= lo && q < hi) ? pol : !pol;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag);
        chk({tag, ".h_q"},    h_q,    mh);
        chk({tag, ".h_act"},  h_act,  mh < HA);
        chk({tag, ".h_sync"}, h_sync, m_sync(mh, HS0, HS1, 1'b0));
        chk({tag, ".v_q"},    v_q,    mv);
        chk({tag, ".v_act"},  v_act,  mv < VA);
        chk({tag, ".v_sync"}, v_sync, m_sync(mv, VS0, VS1, 1'b0));
        chk({tag, ".s_q"},    s_q,    ms);
        chk({tag, ".s_act"},  s_act,  ms < SA);
        chk({tag, ".s_sync"}, s_sync, m_sync(ms, SS0, SS1, 1'b1));
    endtask

    // Called just after a falling edge with inputs already applied.
    task automatic tick(input string tag);
        bit etc_h, etc_v, etc_s;
        #1;
        etc_h = m_tc(mh, h_load, h_count, HM);
        etc_v = m_tc(mv, v_load, etc_h, VM);
        etc_s = m_tc(ms, s_load, s_count, SM);
        chk({tag, ".h_tc"}, h_tc, etc_h);
        chk({tag, ".v_tc"}, v_tc, etc_v);
        chk({tag, ".s_tc"}, s_tc, etc_s);
        @(posedge clk);
        mh = m_next(mh, h_load, h_count, int'(h_d), HM);
        mv = m_next(mv, v_load, etc_h, int'(v_d), VM);
        ms = m_next(ms, s_load, s_count, int'(s_d), SM);
        @(negedge clk);
        check_outs(tag);
    endtask

    task automatic rand_s();
        s_count = ($urandom_range(0, 3) != 0);
        s_load  = ($urandom_range(0, 7) == 0);
        s_d     = 4'($urandom_range(0, 15));
    endtask

    initial begin
        int act_cnt, sync_cnt, prev_v, last_chg;

        clear_n = 1'b0;
        h_count = 1'b0; h_load = 1'b0; h_d = '0;
        v_load  = 1'b0; v_d = '0;
        s_count = 1'b0; s_load = 1'b0; s_d = '0;

        @(negedge clk);
        check_outs("reset");
        @(negedge clk);
        check_outs("reset_hold");
        clear_n = 1'b1;
        s_count = 1'b1;

        // Loads: in range, saturated, and load beating count at the wrap point.
        h_load = 1'b1; h_d = 10'd424;
        tick("load424");
        h_d = 10'd1000;
        tick("load_sat");
        h_count = 1'b1; h_d = 10'd5;
        tick("load_cnt");

        // Wrap through 798, 799, 0, 1.
        h_count = 1'b0; h_d = 10'd797;
        tick("wrap_ld");
        h_load = 1'b0; h_count = 1'b1;
        for (int i = 0; i < 4; i++) tick("wrap");

        // Hold at 100.
        h_load = 1'b1; h_count = 1'b0; h_d = 10'd100;
        tick("hold_ld");
        h_load = 1'b0;
        for (int i = 0; i < 10; i++) tick("hold");

        // One full free-running line; measure window widths directly.
        h_load = 1'b1; h_d = 10'd0;
        tick("free_ld");
        h_load = 1'b0; h_count = 1'b1;
        act_cnt = 0; sync_cnt = 0;
        for (int i = 0; i < HM; i++) begin
            tick("free");
            if (h_act === 1'b1)  act_cnt++;
            if (h_sync === 1'b0) sync_cnt++;
        end
        chk("free.active_width", act_cnt, HA);
        chk("free.sync_width", sync_cnt, HS1 - HS0);
        chk("free.period_q", h_q, 0);

        // Randomised mix of loads (including out-of-range D), counts and holds.
        for (int i = 0; i < 3000; i++) begin
            h_count = ($urandom_range(0, 7) != 0);
            h_load  = ($urandom_range(0, 15) == 0);
            h_d     = 10'($urandom_range(0, 1023));
            v_load  = ($urandom_range(0, 63) == 0);
            v_d     = 10'($urandom_range(0, 1023));
            rand_s();
            tick("rand");
        end

        // Cascade: V starts at 488, so lines 490-491 carry its sync pulse.
        h_load = 1'b1; h_d = 10'd0; h_count = 1'b1;
        v_load = 1'b1; v_d = 10'd488;
        tick("casc_ld");
        h_load = 1'b0; v_load = 1'b0;
        prev_v = 488; last_chg = -1; sync_cnt = 0;
        for (int i = 0; i < 5 * HM; i++) begin
            rand_s();
            tick("casc");
            if (int'(v_q) != prev_v) begin
                if (last_chg >= 0) chk("casc.v_period", i - last_chg, HM);
                last_chg = i;
                prev_v = int'(v_q);
            end
            if (v_sync === 1'b0) sync_cnt++;
        end
        chk("casc.v_sync_width", sync_cnt, (VS1 - VS0) * HM);

        // Both counters at their last value wrap to 0 on the same edge.
        h_load = 1'b1; h_d = 10'd790;
        v_load = 1'b1; v_d = 10'd524;
        tick("casc_wrap_ld");
        h_load = 1'b0; v_load = 1'b0;
        for (int i = 0; i < 10; i++) tick("casc_wrap");
        chk("casc_wrap.h_zero", h_q, 0);
        chk("casc_wrap.v_zero", v_q, 0);

        // Asynchronous clear in the middle of a cycle with Q=300.
        h_load = 1'b1; h_d = 10'd297; h_count = 1'b0;
        tick("rst_ld");
        h_load = 1'b0; h_count = 1'b1;
        for (int i = 0; i < 3; i++) tick("rst_pre");
        chk("rst_pre.h_q300", h_q, 300);
        #2;
        clear_n = 1'b0;
        #1;
        mh = 0; mv = 0; ms = 0;
        check_outs("rst_async");
        chk("rst_async.h_tc", h_tc, 0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_outs("rst_held");
        end
        clear_n = 1'b1;
        tick("rst_release");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_sync_counter.md
# vga_sync_counter

Parametrised modulo-N timing counter for the VGA controller, the successor to the fixed 10-bit `counter`. It counts pixel or line positions, wraps at a programmable modulus, and produces registered active-video and sync outputs aligned with `Q`. It also produces a terminal-count carry, so two instances can cascade as a horizontal counter driving a vertical counter.

## Interface
Parameters:
- `WIDTH`, 10: counter width; must satisfy 2^WIDTH ≥ `MODULUS`.
- `MODULUS`, 800: count sequence is 0 … `MODULUS`-1; must be ≥ 2.
- `ACTIVE`, 640: `Active` is high for Q in [0, `ACTIVE`).
- `SYNC_START`, 656: first Q value of the sync pulse.
- `SYNC_END`, 752: first Q value after the sync pulse; requires `SYNC_START` < `SYNC_END` ≤ `MODULUS`.
- `SYNC_POL`, 0: asserted level of `Sync` (0 = active-low pulse).

Ports:
- `Clock`  in  1  single clock; all state changes on the rising edge.
- `Clear`  in  1  reset; asynchronous, active-low.
- `Count`  in  1  count enable.
- `Load`  in  1  synchronous parallel load of `D`.
- `D`  in  `WIDTH`  load value.
- `Q`  out  `WIDTH`  current count.
- `Tc`  out  1  terminal count / cascade carry; combinational.
- `Active`  out  1  registered; high when Q < `ACTIVE`.
- `Sync`  out  1  registered; equals `SYNC_POL` when `SYNC_START` ≤ Q < `SYNC_END`, otherwise ~`SYNC_POL`.

## Operation
- **Reset.** `Clear`=0 forces the following immediately, regardless of `Clock`, and they hold while `Clear`=0:
  - `Q`=0, `Active`=1, `Sync`=~`SYNC_POL`.
  - `Tc`=0, since Q=0 and `MODULUS`≥2.
- **Next-state priority per edge** (`Clear`=1): `Load` > `Count` > hold.
- **Load.** Q_next = `D` if `D` < `MODULUS`, else `MODULUS`-1 (saturate). Out-of-range values are never stored.
- **Count.** Q_next = Q+1. When Q = `MODULUS`-1, Q_next = 0 (wrap). No intermediate value may exceed `WIDTH` bits.
- **Hold.** `Load`=0 and `Count`=0: Q unchanged.
- **Tc** = `Count` & ~`Load` & (Q == `MODULUS`-1).
  - It is asserted during exactly the cycle in which the counter wraps on the next edge.
  - Connect it to the `Count` input of a downstream instance.
- **Active and Sync.** Both are computed from Q_next and registered on the same edge as Q, so they always describe the current Q. There is no pipeline offset.
- **Simultaneous Load and Count.** Load wins. `Tc` is 0 in that cycle even if Q = `MODULUS`-1.
- **Reset mid-count.** Asynchronous reset takes effect within the same cycle. On the first edge after `Clear` rises, the counter resumes according to the priority rules above.

## Timing
- Latency from `Load`/`Count` to `Q`, `Active` and `Sync`: 1 clock edge.
- `Tc`: combinational from `Q`, `Count` and `Load`, valid before the edge; no registered delay.
- In cascade, the downstream counter advances on the same edge on which the upstream counter wraps to 0.
- Period with `Count` held at 1: exactly `MODULUS` cycles.
- `Sync` pulse width: `SYNC_END`-`SYNC_START` cycles.
- `Active` width: `ACTIVE` cycles.
- There is no state machine beyond the counter register; Q is the only state besides the two output flops.

## Structure
- Shared package `vga_timing_pkg`:
  - 640x480@60 constants. H: 800 / 640 / 656 / 752. V: 525 / 480 / 490 / 492. Polarity: 0 for both.
  - Default `WIDTH`=10.
- Sub-module `vga_window_cmp`: half-open window compare lo ≤ x < hi, parametrised on width and bounds. It is instantiated twice, once for Active (lo=0) and once for Sync.
- Elaboration-time parameter checks: `MODULUS` ≥ 2, `MODULUS` ≤ 2^`WIDTH`, and window ordering.

## Test plan
- **Reset.** `Clear`=0 mid-cycle with Q=300 -> Q=0, `Active`=1, `Sync`=1 (`SYNC_POL`=0) before the next edge, and held while `Clear`=0.
- **Load.**
  - `Load`=1, `D`=424 -> Q=424 after one edge.
  - `D`=1000 -> Q=799 (saturated).
  - `Load`=1 and `Count`=1 with `D`=5 -> Q=5, and `Tc`=0.
- **Wrap.** Load 797, then `Count`=1 for 4 edges -> Q = 798, 799, 0, 1. `Tc`=1 only while Q=799.
- **Windows.** Free-run from 0 for 800 edges:
  - `Active`=1 for Q 0–639 and 0 at Q=640.
  - `Sync`=0 for Q 656–751 (96 cycles) and 1 at Q=752.
- **Hold.** `Count`=0 at Q=100 for 10 edges -> Q, `Active` and `Sync` unchanged; `Tc`=0.
- **Cascade.** H instance (800) `Tc` drives `Count` of V instance (525), with H `Count`=1:
  - V increments once every 800 cycles.
  - After 420000 cycles, both counters are back to 0.
  - V `Sync` is low for lines 490–491.
